// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between N masters and the round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface arbiter_rr_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned W = (N <= 2) ? 1 : $clog2(N);

  logic [N-1:0] r;
  logic [N-1:0] g;
  logic [W-1:0] gid;
  logic         busy;

  modport master (output r, input g, gid, busy);
  modport slave  (input r, output g, gid, busy);
endinterface

// File: rtl/arbiter_rr.sv
// Round-robin arbiter for N requesters with registered one-hot grant, binary index
// and an optional hold limit that forces rotation while others are waiting.
module arbiter_rr #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         ck,
  input  logic         reset,
  arbiter_rr_if.slave  bus
);
  localparam int unsigned W   = (N <= 2) ? 1 : $clog2(N);
  localparam int unsigned HcW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HcW-1:0] HcMax   = HcW'(MAX_HOLD);
  localparam logic [W-1:0]   LastIdx = W'(N - 1);
  localparam bit             Limited = (MAX_HOLD != 0);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   g_q, g_d;
  logic [W-1:0]   gid_q, gid_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [HcW-1:0] hc_q, hc_d;

  logic [N-1:0]   others;
  logic           own_req;
  logic           do_grant;
  logic [N-1:0]   grant_src;
  logic [W-1:0]   k;

  // First set bit of v scanning p, p+1, ..., wrapping modulo N. Iterating from the
  // far end lets the nearest candidate win by being assigned last.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v, input logic [W-1:0] p);
    logic [W-1:0] res;
    int unsigned  idx;
    res = p;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N;
      if (v[idx]) res = W'(idx);
    end
    return res;
  endfunction

  assign others  = bus.r & ~g_q;
  assign own_req = |(bus.r & g_q);
  assign k       = pick(grant_src, ptr_q);

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    gid_d     = gid_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    hc_d      = hc_q;
    do_grant  = 1'b0;
    grant_src = bus.r;

    unique case (state_q)
      StIdle: begin
        if (|bus.r) begin
          do_grant  = 1'b1;
          grant_src = bus.r;
        end
      end
      StGrant: begin
        grant_src = others;
        if (!own_req) begin
          if (|others) begin
            do_grant = 1'b1;
          end else begin
            state_d = StIdle;
            g_d     = '0;
            gid_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (Limited && (hc_q == HcMax) && (|others)) begin
          do_grant = 1'b1;
        end else if (Limited && (hc_q < HcMax)) begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // New owner drops to lowest priority for the next arbitration.
    if (do_grant) begin
      state_d = StGrant;
      g_d     = {{(N-1){1'b0}}, 1'b1} << k;
      gid_d   = k;
      busy_d  = 1'b1;
      ptr_d   = (k == LastIdx) ? '0 : k + 1'b1;
      hc_d    = HcW'(1);
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      g_q     <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hc_q    <= hc_d;
    end
  end

  assign bus.g    = g_q;
  assign bus.gid  = gid_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr (N = 4, MAX_HOLD = 4): vector table plus
// hand-written multi-cycle sequences.
module tb_arbiter_rr;
  logic ck;
  logic reset;
  int   n_total;
  int   n_pass;

  arbiter_rr_if #(.N(4)) bus ();

  arbiter_rr #(.N(4), .MAX_HOLD(4)) u_dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    ck = 1'b0;
    forever #10 ck = ~ck;
  end

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] egid,
                       input logic ebusy);
    n_total++;
    if (bus.g === eg && bus.gid === egid && bus.busy === ebusy) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got g=%b gid=%0d busy=%b, want g=%b gid=%0d busy=%b",
               name, bus.g, bus.gid, bus.busy, eg, egid, ebusy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.r = 4'b0000;
    @(negedge ck);
    @(negedge ck);
    reset = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    bus.r   = 4'b0000;

    // Cycle-by-cycle vectors from reset: ptr starts at 0.
    tbl[0]  = '{4'b0010, 4'b0010, 2'd1, 1'b1}; // single request
    tbl[1]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0}; // release, ptr=2
    tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0100, 2'd2, 1'b1}; // pick from ptr=2
    tbl[5]  = '{4'b1111, 4'b0100, 2'd2, 1'b1};
    tbl[6]  = '{4'b1111, 4'b0100, 2'd2, 1'b1};
    tbl[7]  = '{4'b1111, 4'b0100, 2'd2, 1'b1};
    tbl[8]  = '{4'b1111, 4'b1000, 2'd3, 1'b1}; // preempt after 4 cycles
    tbl[9]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1}; // zero-gap handoff, wraps to 0
    tbl[11] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
    tbl[12] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    // Reset state with requests pending: nothing granted while reset holds.
    bus.r = 4'b1111;
    @(negedge ck);
    check("reset_state", 4'b0000, 2'd0, 1'b0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      bus.r = tbl[i].r;
      @(negedge ck);
      check($sformatf("vec%0d", i), tbl[i].g, tbl[i].gid, tbl[i].busy);
    end

    // Fair rotation: four cycles per owner, no idle gap.
    do_reset();
    bus.r = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      @(negedge ck);
      check($sformatf("rot%0d", c), 4'b0001 << ((c / 4) % 4), 2'((c / 4) % 4), 1'b1);
    end

    // Handoff from owner 2 to 3.
    do_reset();
    bus.r = 4'b0100;
    @(negedge ck);
    check("hand_own2", 4'b0100, 2'd2, 1'b1);
    bus.r = 4'b1100;
    @(negedge ck);
    check("hand_hold", 4'b0100, 2'd2, 1'b1);
    bus.r = 4'b1000;
    @(negedge ck);
    check("hand_to3", 4'b1000, 2'd3, 1'b1);

    // No preemption without contenders.
    do_reset();
    bus.r = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge ck);
      check($sformatf("solo%0d", c), 4'b0001, 2'd0, 1'b1);
    end
    n_total++;
    if (u_dut.hc_q === 3'd4) n_pass++;
    else $display("FAIL solo_hc_sat: got hc=%0d, want 4", u_dut.hc_q);

    // Wrap-around priority after owner 3.
    do_reset();
    bus.r = 4'b1000;
    @(negedge ck);
    check("wrap_own3", 4'b1000, 2'd3, 1'b1);
    bus.r = 4'b0000;
    @(negedge ck);
    check("wrap_idle", 4'b0000, 2'd0, 1'b0);
    bus.r = 4'b1001;
    @(negedge ck);
    check("wrap_to0", 4'b0001, 2'd0, 1'b1);

    // Asynchronous reset pulse between edges.
    do_reset();
    bus.r = 4'b0100;
    @(negedge ck);
    check("async_pre", 4'b0100, 2'd2, 1'b1);
    #2 reset = 1'b1;
    #5 reset = 1'b0;
    #1;
    check("async_clear", 4'b0000, 2'd0, 1'b0);
    bus.r = 4'b1111;
    @(negedge ck);
    check("async_after", 4'b0001, 2'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
